sc_speedlevel_ctrl: RTL and testbench

Sequencer for the free-running speed counter (SC_upSPEEDCOUNTER). It drives the counter's active-low upcount and clear inputs and watches the counter value. Each time the value reaches a level-dependent threshold, it emits a one-cycle tick and restarts the count. After a fixed number of ticks it steps a speed level, which sets the pace for game/display logic at the top level.

---
 rtl/sc_speedctrl_pkg.sv | 19 +
 rtl/sc_speedctrl_levelcnt.sv | 53 +++++
 rtl/sc_speedlevel_ctrl.sv | 110 +++++++++++
 tb/tb_sc_speedlevel_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sc_speedctrl_pkg.sv
// Shared definitions for the speed-level sequencer: FSM encoding, level ceiling
// and the default tick periods for a 50 MHz clock.
package sc_speedctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sc_state_e;

  localparam logic [1:0] LEVEL_MAX = 2'd3;

  localparam int          SC_DATAWIDTH_DEFAULT = 23;
  localparam logic [22:0] SC_THRESH0_DEFAULT   = 23'd5000000;
  localparam logic [22:0] SC_THRESH1_DEFAULT   = 23'd2500000;
  localparam logic [22:0] SC_THRESH2_DEFAULT   = 23'd1250000;
  localparam logic [22:0] SC_THRESH3_DEFAULT   = 23'd625000;

endpackage

// File: rtl/sc_speedctrl_levelcnt.sv
// Counts period ticks and steps a saturating 0..3 speed level every
// TICKS_PER_LEVEL ticks; a restart request returns both to zero.
module sc_speedctrl_levelcnt
  import sc_speedctrl_pkg::*;
#(
  parameter int TICKS_PER_LEVEL = 16
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       tick_i,
  input  logic       restart_i,
  output logic [1:0] level_o
);

  localparam int            TW        = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_LEVEL - 1);

  logic [TW-1:0] tickCnt_q, tickCnt_d;
  logic [1:0]    level_q, level_d;

  // Once the level saturates the tick counter keeps wrapping so the
  // pacing stays consistent with earlier levels.
  always_comb begin
    tickCnt_d = tickCnt_q;
    level_d   = level_q;
    if (restart_i) begin
      tickCnt_d = '0;
      level_d   = 2'd0;
    end else if (tick_i) begin
      if (tickCnt_q == TICK_LAST) begin
        tickCnt_d = '0;
        if (level_q != LEVEL_MAX) begin
          level_d = level_q + 2'd1;
        end
      end else begin
        tickCnt_d = tickCnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      tickCnt_q <= '0;
      level_q   <= 2'd0;
    end else begin
      tickCnt_q <= tickCnt_d;
      level_q   <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/sc_speedlevel_ctrl.sv
// Sequencer for the external free-running speed counter: restarts it at a
// level-dependent threshold, emits a tick per period and steps the speed level.
module sc_speedlevel_ctrl
  import sc_speedctrl_pkg::*;
#(
  parameter int                   DATAWIDTH       = SC_DATAWIDTH_DEFAULT,
  parameter logic [DATAWIDTH-1:0] THRESH0         = DATAWIDTH'(SC_THRESH0_DEFAULT),
  parameter logic [DATAWIDTH-1:0] THRESH1         = DATAWIDTH'(SC_THRESH1_DEFAULT),
  parameter logic [DATAWIDTH-1:0] THRESH2         = DATAWIDTH'(SC_THRESH2_DEFAULT),
  parameter logic [DATAWIDTH-1:0] THRESH3         = DATAWIDTH'(SC_THRESH3_DEFAULT),
  parameter int                   TICKS_PER_LEVEL = 16
) (
  input  logic                 SC_upSPEEDCOUNTER_CLOCK_50,
  input  logic                 SC_upSPEEDCOUNTER_RESET_InHigh,
  input  logic                 start_InLow,
  input  logic                 pause_InLow,
  input  logic [DATAWIDTH-1:0] count_data_InBUS,
  output logic                 upcount_OutLow,
  output logic                 clear_OutLow,
  output logic                 tick_OutHigh,
  output logic [1:0]           level_OutBUS,
  output logic [1:0]           state_OutBUS
);

  sc_state_e            state_q, state_d;
  logic                 tick_q, tick_d;
  logic [1:0]           level;
  logic [DATAWIDTH-1:0] threshSel;
  logic [DATAWIDTH-1:0] threshLast;
  logic                 thresholdHit;
  logic                 startReq;

  always_comb begin
    unique case (level)
      2'd0:    threshSel = THRESH0;
      2'd1:    threshSel = THRESH1;
      2'd2:    threshSel = THRESH2;
      default: threshSel = THRESH3;
    endcase
  end

  // Greater-or-equal so a counter that somehow overshoots is still recovered.
  assign threshLast   = threshSel - DATAWIDTH'(1);
  assign thresholdHit = (count_data_InBUS >= threshLast);
  assign startReq     = ~start_InLow;

  // Priority inside RUN: restart, then threshold clear, then pause; a
  // threshold hit still clears and ticks even when pause arrives with it.
  always_comb begin
    state_d        = state_q;
    tick_d         = 1'b0;
    upcount_OutLow = 1'b1;
    clear_OutLow   = 1'b1;
    unique case (state_q)
      IDLE: begin
        clear_OutLow = 1'b0;
        if (startReq) state_d = RUN;
      end
      RUN: begin
        upcount_OutLow = 1'b0;
        if (startReq) begin
          clear_OutLow = 1'b0;
        end else if (thresholdHit) begin
          clear_OutLow = 1'b0;
          tick_d       = 1'b1;
          if (!pause_InLow) state_d = PAUSE;
        end else if (!pause_InLow) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (startReq) begin
          clear_OutLow = 1'b0;
          state_d      = RUN;
        end else if (pause_InLow) begin
          state_d = RUN;
        end
      end
      default: begin
        clear_OutLow = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge SC_upSPEEDCOUNTER_CLOCK_50 or posedge SC_upSPEEDCOUNTER_RESET_InHigh) begin
    if (SC_upSPEEDCOUNTER_RESET_InHigh) begin
      state_q <= IDLE;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
    end
  end

  sc_speedctrl_levelcnt #(
    .TICKS_PER_LEVEL(TICKS_PER_LEVEL)
  ) uLevelCnt (
    .clock_i  (SC_upSPEEDCOUNTER_CLOCK_50),
    .reset_i  (SC_upSPEEDCOUNTER_RESET_InHigh),
    .tick_i   (tick_q),
    .restart_i(startReq),
    .level_o  (level)
  );

  assign tick_OutHigh = tick_q;
  assign level_OutBUS = level;
  assign state_OutBUS = state_q;

endmodule

// File: tb/tb_sc_speedlevel_ctrl.sv
// Bench for sc_speedlevel_ctrl with a behavioural speed counter beside it;
// expected tick spacing and levels come from the period table and tick index.
module tb_sc_speedlevel_ctrl;

  localparam int DW  = 23;
  localparam int TPL = 2;

  int threshTab [4] = '{8, 6, 4, 2};

  logic          clk;
  logic          rst;
  logic          startN;
  logic          pauseN;
  logic [DW-1:0] countQ;
  logic          upN;
  logic          clrN;
  logic          tick;
  logic [1:0]    level;
  logic [1:0]    state;

  int vectors    = 0;
  int miscompares = 0;
  int edgeCnt    = 0;

  sc_speedlevel_ctrl #(
    .DATAWIDTH      (DW),
    .THRESH0        (23'd8),
    .THRESH1        (23'd6),
    .THRESH2        (23'd4),
    .THRESH3        (23'd2),
    .TICKS_PER_LEVEL(TPL)
  ) dut (
    .SC_upSPEEDCOUNTER_CLOCK_50    (clk),
    .SC_upSPEEDCOUNTER_RESET_InHigh(rst),
    .start_InLow                   (startN),
    .pause_InLow                   (pauseN),
    .count_data_InBUS              (countQ),
    .upcount_OutLow                (upN),
    .clear_OutLow                  (clrN),
    .tick_OutHigh                  (tick),
    .level_OutBUS                  (level),
    .state_OutBUS                  (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The up-counter the sequencer drives: synchronous active-low clear
  // dominates the active-low count enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        countQ <= '0;
    else if (!clrN) countQ <= '0;
    else if (!upN)  countQ <= countQ + 23'd1;
  end

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  function automatic int expLevel(input int k);
    int lv;
    lv = k / TPL;
    if (lv > 3) lv = 3;
    return lv;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic p);
    startN = s;
    pauseN = p;
  endtask

  task automatic waitTick(input int budget, output int tickEdge);
    bit found;
    found = 1'b0;
    tickEdge = -1;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        tickEdge = edgeCnt;
        found = 1'b1;
      end
    end
    if (!found) tickEdge = edgeCnt;
  endtask

  initial begin
    int tEdge, prev, startEdge, d, pLen, r, sawTick;

    rst = 1'b1;
    applyStimulus(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("rst_upcount", upN, 1);
    checkOutput("rst_clear", clrN, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_state", state, 0);
    checkOutput("rst_tick", tick, 0);

    rst = 1'b0;
    sawTick = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tick !== 1'b0) sawTick = 1;
    end
    checkOutput("idle_no_tick", sawTick, 0);
    checkOutput("idle_upcount", upN, 1);
    checkOutput("idle_clear", clrN, 0);
    checkOutput("idle_count", countQ, 0);
    checkOutput("idle_state", state, 0);

    // First start: tick arrives THRESH0 edges after the sampling edge.
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1);
    startEdge = edgeCnt;
    checkOutput("start_state", state, 1);
    checkOutput("start_count", countQ, 0);
    waitTick(40, tEdge);
    checkOutput("tick0_gap", tEdge - startEdge, threshTab[expLevel(0)]);
    checkOutput("tick0_level", level, expLevel(0));
    prev = tEdge;

    // Pause mid-period at level 0: the period grows by the pause length.
    d    = $urandom_range(1, 5);
    pLen = $urandom_range(2, 6);
    repeat (d) @(negedge clk);
    checkOutput("prepause_count", countQ, d);
    applyStimulus(1'b1, 1'b0);
    repeat (pLen) @(negedge clk);
    checkOutput("pause_state", state, 2);
    checkOutput("pause_frozen", countQ, d + 1);
    applyStimulus(1'b1, 1'b1);
    waitTick(40, tEdge);
    checkOutput("pause_gap", tEdge - prev, threshTab[expLevel(1)] + pLen);
    prev = tEdge;

    waitTick(40, tEdge);
    checkOutput("tick2_gap", tEdge - prev, threshTab[expLevel(2)]);
    checkOutput("tick2_level", level, expLevel(2));
    prev = tEdge;

    // Pause arriving in the threshold-hit cycle.
    repeat (threshTab[expLevel(3)] - 1) @(negedge clk);
    checkOutput("hit_count", countQ, threshTab[expLevel(3)] - 1);
    checkOutput("hit_clear", clrN, 0);
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1);
    checkOutput("hit_tick", tick, 1);
    checkOutput("hit_count_zero", countQ, 0);
    checkOutput("hit_state", state, 2);
    checkOutput("hit_gap", edgeCnt - prev, threshTab[expLevel(3)]);
    prev = edgeCnt;
    waitTick(40, tEdge);
    checkOutput("tick4_gap", tEdge - prev, threshTab[expLevel(4)] + 1);
    checkOutput("tick4_level", level, expLevel(4));

    // Restart while at level 2.
    r = $urandom_range(1, 2);
    repeat (r) @(negedge clk);
    checkOutput("prerestart_level", level, 2);
    applyStimulus(1'b0, 1'b1);
    #1;
    checkOutput("restart_clear", clrN, 0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1);
    startEdge = edgeCnt;
    checkOutput("restart_count", countQ, 0);
    checkOutput("restart_level", level, 0);
    checkOutput("restart_tick", tick, 0);
    checkOutput("restart_state", state, 1);

    // Full level ramp with random pauses inserted at period starts.
    prev = startEdge;
    for (int k = 0; k < 9; k++) begin
      pLen = 0;
      if ($urandom_range(0, 1) == 1) begin
        pLen = $urandom_range(1, 4);
        applyStimulus(1'b1, 1'b0);
        repeat (pLen) @(negedge clk);
        applyStimulus(1'b1, 1'b1);
      end
      waitTick(60, tEdge);
      checkOutput($sformatf("ramp_gap%0d", k), tEdge - prev, threshTab[expLevel(k)] + pLen);
      checkOutput($sformatf("ramp_level%0d", k), level, expLevel(k));
      prev = tEdge;
    end
    @(negedge clk);
    checkOutput("ramp_saturated", level, 3);

    // Reset mid-period at level 1.
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1);
    prev = edgeCnt;
    for (int k = 0; k < 2; k++) begin
      waitTick(40, tEdge);
      checkOutput($sformatf("prereset_gap%0d", k), tEdge - prev, threshTab[expLevel(k)]);
      prev = tEdge;
    end
    d = $urandom_range(1, 4);
    repeat (d) @(negedge clk);
    checkOutput("prereset_level", level, 1);
    rst = 1'b1;
    #1;
    checkOutput("areset_state", state, 0);
    checkOutput("areset_level", level, 0);
    checkOutput("areset_tick", tick, 0);
    checkOutput("areset_upcount", upN, 1);
    checkOutput("areset_clear", clrN, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sawTick = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tick !== 1'b0) sawTick = 1;
    end
    checkOutput("postreset_no_tick", sawTick, 0);
    checkOutput("postreset_state", state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
